// File: rtl/autoc.sv
// rtl/autoc.sv - delay-and-correlate autocorrelator for RX preamble detection
//
// Purpose:
//   For each strobed complex sample x[n] computes p[n] = x[n] * conj(x[n-DELAY])
//   and keeps the exact moving sum of p over the last DELAY samples. The top
//   WIDTH bits of that sum are presented as si/sq.
//
// Ports:
//   clk             posedge clock
//   rst             synchronous, active-high reset
//   ddc_out_sample  DDC sample, I=[31:16], Q=[15:0], signed
//   ddc_out_strobe  sample valid, may be high every cycle
//   ddc_out_enable  registered copy of enable, requests the DDC to run
//   enable          block enable, low acts as a synchronous clear
//   si, sq          real/imaginary windowed correlation, signed, floor-truncated
//   outputting      high once the window holds 2*DELAY samples' worth of data
//
// Pipeline: sample capture (edge t) -> product (t+1) -> accumulator (t+2).

module autoc #(
    parameter int WIDTH = 24,
    parameter int DELAY = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ddc_out_sample,
    input  logic             ddc_out_strobe,
    output logic             ddc_out_enable,
    input  logic             enable,
    output logic [WIDTH-1:0] si,
    output logic [WIDTH-1:0] sq,
    output logic             outputting
);

    localparam int DW    = $clog2(DELAY);
    localparam int ACC_W = 33 + DW;
    localparam int CNT_W = DW + 2;
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(2 * DELAY);

    logic clear;
    assign clear = rst | ~enable;

    // Stage 0: newest sample and the sample DELAY positions older
    logic [31:0]        x_dly_q [DELAY];
    logic [31:0]        xa_q, xb_q;
    logic               v0_q, full0_q;
    logic [CNT_W-1:0]   fill_q;

    // Stage 1: full-precision product
    logic signed [32:0] pr_q, pi_q;
    logic               v1_q, full1_q;

    // Stage 2: product history and window accumulator
    logic signed [32:0]      pr_dly_q [DELAY];
    logic signed [32:0]      pi_dly_q [DELAY];
    logic signed [ACC_W-1:0] acc_r_q, acc_i_q;
    logic signed [ACC_W-1:0] acc_r_d, acc_i_d;
    logic                    out_q, ddc_en_q;

    logic signed [32:0] ia, qa, ib, qb;
    logic signed [32:0] pr_d, pi_d;

    assign ia = {{17{xa_q[31]}}, xa_q[31:16]};
    assign qa = {{17{xa_q[15]}}, xa_q[15:0]};
    assign ib = {{17{xb_q[31]}}, xb_q[31:16]};
    assign qb = {{17{xb_q[15]}}, xb_q[15:0]};

    // a * conj(b); each partial product fits 31 bits, the sum fits 33
    assign pr_d = ia * ib + qa * qb;
    assign pi_d = qa * ib - ia * qb;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [32:0] v);
        return {{(ACC_W-33){v[32]}}, v};
    endfunction

    // Add the entering product, remove the one leaving the window
    always_comb begin
        acc_r_d = acc_r_q + sext(pr_q) - sext(pr_dly_q[DELAY-1]);
        acc_i_d = acc_i_q + sext(pi_q) - sext(pi_dly_q[DELAY-1]);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int k = 0; k < DELAY; k++) begin
                x_dly_q[k]  <= '0;
                pr_dly_q[k] <= '0;
                pi_dly_q[k] <= '0;
            end
            xa_q     <= '0;
            xb_q     <= '0;
            v0_q     <= 1'b0;
            full0_q  <= 1'b0;
            fill_q   <= '0;
            pr_q     <= '0;
            pi_q     <= '0;
            v1_q     <= 1'b0;
            full1_q  <= 1'b0;
            acc_r_q  <= '0;
            acc_i_q  <= '0;
            out_q    <= 1'b0;
            ddc_en_q <= 1'b0;
        end else begin
            ddc_en_q <= 1'b1;

            v0_q <= ddc_out_strobe;
            if (ddc_out_strobe) begin
                xa_q       <= ddc_out_sample;
                xb_q       <= x_dly_q[DELAY-1];
                x_dly_q[0] <= ddc_out_sample;
                for (int k = 1; k < DELAY; k++) begin
                    x_dly_q[k] <= x_dly_q[k-1];
                end
                if (fill_q != FILL_MAX) begin
                    fill_q <= fill_q + 1'b1;
                end
                // Marks the 2*DELAY-th sample (and every one after it)
                full0_q <= (fill_q >= FILL_MAX - 1'b1);
            end

            v1_q    <= v0_q;
            full1_q <= full0_q;
            if (v0_q) begin
                pr_q <= pr_d;
                pi_q <= pi_d;
            end

            if (v1_q) begin
                acc_r_q     <= acc_r_d;
                acc_i_q     <= acc_i_d;
                pr_dly_q[0] <= pr_q;
                pi_dly_q[0] <= pi_q;
                for (int k = 1; k < DELAY; k++) begin
                    pr_dly_q[k] <= pr_dly_q[k-1];
                    pi_dly_q[k] <= pi_dly_q[k-1];
                end
                if (full1_q) begin
                    out_q <= 1'b1;
                end
            end
        end
    end

    assign si             = acc_r_q[ACC_W-1 -: WIDTH];
    assign sq             = acc_i_q[ACC_W-1 -: WIDTH];
    assign outputting     = out_q;
    assign ddc_out_enable = ddc_en_q;

endmodule

// File: tb/tb_autoc.sv
// tb/tb_autoc.sv - directed self-checking bench for autoc

module tb_autoc;

    localparam int WIDTH = 24;
    localparam int DELAY = 32;
    localparam int SHIFT = 33 + $clog2(DELAY) - WIDTH;

    logic             clk;
    logic             rst;
    logic [31:0]      ddc_out_sample;
    logic             ddc_out_strobe;
    logic             ddc_out_enable;
    logic             enable;
    logic [WIDTH-1:0] si;
    logic [WIDTH-1:0] sq;
    logic             outputting;

    int n_checks = 0;
    int n_pass   = 0;

    int hist_i [256];
    int hist_q [256];
    int n_fed = 0;

    autoc #(.WIDTH(WIDTH), .DELAY(DELAY)) dut (
        .clk            (clk),
        .rst            (rst),
        .ddc_out_sample (ddc_out_sample),
        .ddc_out_strobe (ddc_out_strobe),
        .ddc_out_enable (ddc_out_enable),
        .enable         (enable),
        .si             (si),
        .sq             (sq),
        .outputting     (outputting)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic longint s_i();
        return longint'($signed(si));
    endfunction

    function automatic longint s_q();
        return longint'($signed(sq));
    endfunction

    // Independent reference: direct sum of x[k]*conj(x[k-DELAY]) over the last DELAY samples
    function automatic longint model_acc(input bit imag);
        longint s, ai, aq, bi, bq;
        s = 0;
        for (int k = n_fed - DELAY; k < n_fed; k++) begin
            if (k >= 0) begin
                ai = hist_i[k];
                aq = hist_q[k];
                bi = 0;
                bq = 0;
                if (k >= DELAY) begin
                    bi = hist_i[k-DELAY];
                    bq = hist_q[k-DELAY];
                end
                s += imag ? (aq * bi - ai * bq) : (ai * bi + aq * bq);
            end
        end
        return s;
    endfunction

    task automatic feed(input int n, input int i0, input int q0,
                        input int di, input int dq, input int gap);
        logic [31:0] ti, tq;
        for (int k = 0; k < n; k++) begin
            ti = i0 + k * di;
            tq = q0 + k * dq;
            @(negedge clk);
            ddc_out_sample = {ti[15:0], tq[15:0]};
            ddc_out_strobe = 1'b1;
            if (n_fed < 256) begin
                hist_i[n_fed] = int'($signed(ti[15:0]));
                hist_q[n_fed] = int'($signed(tq[15:0]));
                n_fed++;
            end
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                ddc_out_strobe = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ddc_out_strobe = 1'b0;
        end
    endtask

    // One-cycle enable drop; checks the cleared state on the following cycle
    task automatic drop_enable(input string tag);
        @(negedge clk);
        enable         = 1'b0;
        ddc_out_strobe = 1'b1;
        @(negedge clk);
        check_eq({tag, "_si"}, s_i(), 0);
        check_eq({tag, "_sq"}, s_q(), 0);
        check_eq({tag, "_out"}, longint'(outputting), 0);
        check_eq({tag, "_ddcen"}, longint'(ddc_out_enable), 0);
        enable         = 1'b1;
        ddc_out_strobe = 1'b0;
        n_fed          = 0;
    endtask

    initial begin
        rst            = 1'b1;
        enable         = 1'b1;
        ddc_out_strobe = 1'b1;
        ddc_out_sample = 32'h1234_5678;

        // Reset holds everything clear even with strobe and enable high
        repeat (2) @(negedge clk);
        check_eq("rst_si", s_i(), 0);
        check_eq("rst_sq", s_q(), 0);
        check_eq("rst_out", longint'(outputting), 0);
        check_eq("rst_ddcen", longint'(ddc_out_enable), 0);
        rst            = 1'b0;
        ddc_out_strobe = 1'b0;
        n_fed          = 0;

        // Constant I=1000, back-to-back; outputting rises exactly at t+2 of sample 64
        feed(64, 1000, 0, 0, 0, 0);
        idle(2);
        check_eq("c1_out_t1", longint'(outputting), 0);
        idle(1);
        check_eq("c1_si", s_i(), 1953);
        check_eq("c1_sq", s_q(), 0);
        check_eq("c1_out", longint'(outputting), 1);
        check_eq("c1_ddcen", longint'(ddc_out_enable), 1);

        // Switch to I=0,Q=1000: half window is pure +j rotation, full window cancels
        feed(32, 0, 1000, 0, 0, 0);
        idle(3);
        check_eq("jq_half_si", s_i(), 0);
        check_eq("jq_half_sq", s_q(), 1953);
        feed(32, 0, 1000, 0, 0, 0);
        idle(3);
        check_eq("jq_si", s_i(), 1953);
        check_eq("jq_sq", s_q(), 0);

        // I=Q=1000: half window gives -j component (floor of negative), full window real only
        feed(32, 1000, 1000, 0, 0, 0);
        idle(3);
        check_eq("iq_half_si", s_i(), 1953);
        check_eq("iq_half_sq", s_q(), -1954);
        feed(32, 1000, 1000, 0, 0, 0);
        idle(3);
        check_eq("iq_si", s_i(), 3906);
        check_eq("iq_sq", s_q(), 0);

        // Sign flip: +1000 then -1000 gives -32e6, floored to -1954
        drop_enable("clr1");
        feed(32, 1000, 0, 0, 0, 0);
        feed(32, -1000, 0, 0, 0, 0);
        idle(3);
        check_eq("neg_si", s_i(), -1954);
        check_eq("neg_sq", s_q(), 0);
        check_eq("neg_out", longint'(outputting), 1);

        // Mid-stream enable drop wipes a full window; refill needs 64 again
        drop_enable("clr2");
        feed(63, 1000, 0, 0, 0, 0);
        idle(3);
        check_eq("refill63_si", s_i(), 1892);
        check_eq("refill63_out", longint'(outputting), 0);
        feed(1, 1000, 0, 0, 0, 0);
        idle(3);
        check_eq("refill64_si", s_i(), 1953);
        check_eq("refill64_out", longint'(outputting), 1);

        // Strobe every third cycle
        drop_enable("clr3");
        feed(63, 1000, 0, 0, 0, 2);
        idle(3);
        check_eq("sparse63_si", s_i(), 1892);
        check_eq("sparse63_out", longint'(outputting), 0);
        feed(1, 1000, 0, 0, 0, 0);
        idle(2);
        check_eq("sparse_t1_si", s_i(), 1892);
        check_eq("sparse_t1_out", longint'(outputting), 0);
        idle(1);
        check_eq("sparse_si", s_i(), 1953);
        check_eq("sparse_out", longint'(outputting), 1);
        idle(5);
        check_eq("sparse_hold_si", s_i(), 1953);
        check_eq("sparse_hold_out", longint'(outputting), 1);

        // Ramp against the direct-sum reference
        drop_enable("clr4");
        feed(40, 32'h1024, 32'hBEEF, 1, 2, 0);
        idle(3);
        check_eq("ramp40_si", s_i(), model_acc(1'b0) >>> SHIFT);
        check_eq("ramp40_sq", s_q(), model_acc(1'b1) >>> SHIFT);
        check_eq("ramp40_out", longint'(outputting), 0);
        feed(24, 32'h1024 + 40, 32'hBEEF + 80, 1, 2, 0);
        idle(3);
        check_eq("ramp64_si", s_i(), model_acc(1'b0) >>> SHIFT);
        check_eq("ramp64_sq", s_q(), model_acc(1'b1) >>> SHIFT);
        check_eq("ramp64_out", longint'(outputting), 1);
        feed(20, 32'h1024 + 64, 32'hBEEF + 128, 1, 2, 0);
        idle(3);
        check_eq("ramp84_si", s_i(), model_acc(1'b0) >>> SHIFT);
        check_eq("ramp84_sq", s_q(), model_acc(1'b1) >>> SHIFT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
